// File: rtl/noc_link_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_link_arbiter_pkg
// Purpose  : Shared flit-format constants, FSM encoding and a pointer helper
//            for the NoC link arbiter and its round-robin sub-block.
// Contents : c_flit_w, c_idx_w, c_cred_w, c_credit_max, arb_state_t, next_idx()
// Revision : 1.0  initial release
// ============================================================================
package noc_link_arbiter_pkg;

    localparam int c_flit_w     = 20;  // HEAD = bit 19, TAIL = bit 18
    localparam int c_idx_w      = 3;   // requester index / grant_id width
    localparam int c_cred_w     = 3;   // credit counter width
    localparam int c_credit_max = 7;   // default downstream buffer depth

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Round-robin successor: idx+1, wrapping to 0 after the last requester.
    function automatic logic [c_idx_w-1:0] next_idx(input logic [c_idx_w-1:0] idx,
                                                    input int num_req);
        if (int'(idx) >= num_req - 1)
            return '0;
        return idx + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_link_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : noc_link_arbiter_if
// Purpose  : Bundles the requester-side handshake, the credit return and the
//            link-side outputs of the NoC link arbiter.
// Modports : master - requesters / link sink (drives req_*, ci)
//            slave  - the arbiter (drives req_ready, out_*, grant_id, credits, err)
// Revision : 1.0  initial release
// ============================================================================
interface noc_link_arbiter_if
    import noc_link_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int FLIT_W  = c_flit_w
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*FLIT_W-1:0] req_flit;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      ci;
    logic [FLIT_W-1:0]         out_flit;
    logic                      out_valid;
    logic [c_idx_w-1:0]        grant_id;
    logic [c_cred_w-1:0]       credits;
    logic [1:0]                err;

    modport master (
        output req_valid, req_flit, ci,
        input  req_ready, out_flit, out_valid, grant_id, credits, err
    );

    modport slave (
        input  req_valid, req_flit, ci,
        output req_ready, out_flit, out_valid, grant_id, credits, err
    );
endinterface
`default_nettype wire

// File: rtl/noc_link_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick: first set request at or after
//            the rotating pointer, wrapping around.
// Ports    : i_req  - request vector
//            i_ptr  - highest-priority index this cycle
//            o_gnt  - one-hot grant
//            o_idx  - encoded grant index (0 when nothing granted)
//            o_any  - at least one request granted
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
    import noc_link_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [c_idx_w-1:0] i_ptr,
    output logic      [NUM_REQ-1:0] o_gnt,
    output logic      [c_idx_w-1:0] o_idx,
    output logic                    o_any
);
    // Two passes over constant indices: first the upper segment [ptr..N-1],
    // then the wrapped segment [0..ptr-1].
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_any && i_req[i] && (i >= int'(i_ptr))) begin
                o_gnt[i] = 1'b1;
                o_idx    = 3'(i);
                o_any    = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_any && i_req[i] && (i < int'(i_ptr))) begin
                o_gnt[i] = 1'b1;
                o_idx    = 3'(i);
                o_any    = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/noc_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : noc_link_arbiter
// Purpose  : Wormhole round-robin arbiter sharing one router output link among
//            NUM_REQ requesters, with credit-based downstream flow control.
//            A grant is held from HEAD to TAIL flit.
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous active-low reset
//            link - noc_link_arbiter_if.slave (req_valid/req_flit/req_ready,
//                   ci, out_flit/out_valid, grant_id, credits, err)
// Revision : 1.0  initial release
// ============================================================================
module noc_link_arbiter
    import noc_link_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int FLIT_W  = c_flit_w,
    parameter int CREDITS = c_credit_max
) (
    input  wire logic          clk,
    input  wire logic          rst,
    noc_link_arbiter_if.slave  link
);
    localparam int c_head_bit = FLIT_W - 1;
    localparam int c_tail_bit = FLIT_W - 2;

    arb_state_t           r_state;
    logic [c_idx_w-1:0]   r_ptr;
    logic [c_idx_w-1:0]   r_grant_id;   // doubles as packet owner while LOCKED
    logic [c_cred_w-1:0]  r_credits;
    logic [FLIT_W-1:0]    r_out_flit;
    logic                 r_out_valid;
    logic [1:0]           r_err;

    logic [FLIT_W-1:0]    w_flits [NUM_REQ];
    logic [NUM_REQ-1:0]   w_head;
    logic [NUM_REQ-1:0]   w_elig;
    logic [NUM_REQ-1:0]   w_arb_gnt;
    logic [c_idx_w-1:0]   w_arb_idx;
    logic                 w_arb_any;
    logic [NUM_REQ-1:0]   w_ready;
    logic [c_idx_w-1:0]   w_sel;
    logic [FLIT_W-1:0]    w_flit;
    logic                 w_can;
    logic                 w_own_valid;
    logic                 w_bad_idle;
    logic                 w_send;
    logic                 w_sel_tail;

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
            assign w_flits[g] = link.req_flit[g*FLIT_W +: FLIT_W];
            assign w_head[g]  = w_flits[g][c_head_bit];
        end
    endgenerate

    // Only head flits compete for a free link.
    assign w_elig = link.req_valid & w_head;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .i_req (w_elig),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    always_comb begin
        w_can       = (r_credits != '0);
        w_ready     = '0;
        w_sel       = r_grant_id;
        w_flit      = '0;
        w_own_valid = 1'b0;
        w_bad_idle  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == 3'(i))
                w_own_valid = link.req_valid[i];
        end
        if (r_state == IDLE) begin
            w_sel      = w_arb_idx;
            if (w_can && w_arb_any)
                w_ready = w_arb_gnt;
            // Body/tail flits without an open packet are protocol errors.
            w_bad_idle = |(link.req_valid & ~w_head);
        end else if (w_can && w_own_valid) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (r_grant_id == 3'(i))
                    w_ready[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == 3'(i))
                w_flit = w_flits[i];
        end
        w_send     = |w_ready;
        w_sel_tail = w_flit[c_tail_bit];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_grant_id  <= '0;
            r_credits   <= 3'(CREDITS);
            r_out_flit  <= '0;
            r_out_valid <= 1'b0;
            r_err       <= '0;
        end else begin
            r_out_valid <= w_send;
            if (w_send)
                r_out_flit <= w_flit;

            // Send and credit return in the same cycle cancel out.
            case ({w_send, link.ci})
                2'b10: r_credits <= r_credits - 3'd1;
                2'b01: begin
                    if (r_credits == 3'(CREDITS))
                        r_err[0] <= 1'b1;
                    else
                        r_credits <= r_credits + 3'd1;
                end
                default: ;
            endcase

            if (w_bad_idle)
                r_err[1] <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_send) begin
                        r_grant_id <= w_arb_idx;
                        if (w_sel_tail)
                            r_ptr <= next_idx(w_arb_idx, NUM_REQ);
                        else
                            r_state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (w_send && w_sel_tail) begin
                        r_state <= IDLE;
                        r_ptr   <= next_idx(r_grant_id, NUM_REQ);
                    end
                end
            endcase
        end
    end

    assign link.req_ready = w_ready;
    assign link.out_flit  = r_out_flit;
    assign link.out_valid = r_out_valid;
    assign link.grant_id  = r_grant_id;
    assign link.credits   = r_credits;
    assign link.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_noc_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_link_arbiter
// Purpose  : Directed self-checking bench for noc_link_arbiter. Accepted flits
//            are queued as expected link output and compared one cycle later;
//            a credit model tracks the expected counter.
// Revision : 1.0  initial release
// ============================================================================
module tb_noc_link_arbiter;
    import noc_link_arbiter_pkg::*;

    localparam int N = 4;
    localparam int W = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    noc_link_arbiter_if #(.NUM_REQ(N), .FLIT_W(W)) bus ();

    noc_link_arbiter #(
        .NUM_REQ (N),
        .FLIT_W  (W),
        .CREDITS (7)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .link (bus)
    );

    logic [W-1:0] fl [N];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] last_flit = '0;
    int total  = 0;
    int bad    = 0;
    int m_cred = 7;

    function automatic logic [W-1:0] mk(input logic h, input logic t,
                                        input logic [1:0] src, input logic [15:0] pay);
        return {h, t, src, pay};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive at posedge+2, check req_ready at negedge, check the
    // registered outputs at the following posedge+2.
    task automatic cyc(input logic [N-1:0] v, input logic ci_in,
                       input logic [N-1:0] exp_rdy, input string tag);
        logic         send;
        logic [W-1:0] e;
        bus.req_valid = v;
        bus.req_flit  = {fl[3], fl[2], fl[1], fl[0]};
        bus.ci        = ci_in;
        @(negedge clk);
        chk({tag, ":ready"}, 32'(bus.req_ready), 32'(exp_rdy));
        send = |exp_rdy;
        for (int i = 0; i < N; i++)
            if (exp_rdy[i]) exp_q.push_back(fl[i]);
        if (send && !ci_in)
            m_cred--;
        else if (!send && ci_in && m_cred < 7)
            m_cred++;
        @(posedge clk);
        #2;
        chk({tag, ":out_valid"}, 32'(bus.out_valid), 32'(send));
        if (send && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, ":out_flit"}, 32'(bus.out_flit), 32'(e));
            last_flit = e;
        end else begin
            chk({tag, ":out_flit_hold"}, 32'(bus.out_flit), 32'(last_flit));
        end
        chk({tag, ":credits"}, 32'(bus.credits), 32'(m_cred));
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_flit  = '0;
        bus.ci        = 1'b0;
        for (int i = 0; i < N; i++) fl[i] = '0;

        // Power-on reset
        #1 rst = 1'b0;
        @(posedge clk);
        #2;
        chk("rst_credits",   32'(bus.credits),   32'd7);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_err",       32'(bus.err),       32'd0);
        chk("rst_grant",     32'(bus.grant_id),  32'd0);
        chk("rst_ready",     32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;

        // Contention req0/req2 with ptr=0: req0 packet first, req2 waits
        fl[0] = mk(1'b1, 1'b0, 2'd0, 16'h0a01);
        fl[2] = mk(1'b1, 1'b0, 2'd2, 16'h2a01);
        cyc(4'b0101, 1'b0, 4'b0001, "t3_hd0");
        fl[0] = mk(1'b0, 1'b1, 2'd0, 16'h0a02);
        cyc(4'b0101, 1'b0, 4'b0001, "t3_tl0");
        cyc(4'b0100, 1'b0, 4'b0100, "t3_hd2");
        chk("t3_grant2", 32'(bus.grant_id), 32'd2);
        fl[2] = mk(1'b0, 1'b1, 2'd2, 16'h2a02);
        cyc(4'b0100, 1'b0, 4'b0100, "t3_tl2");
        // ptr=3: req3 idle, wraps to req0
        fl[0] = mk(1'b1, 1'b1, 2'd0, 16'h0b01);
        fl[2] = mk(1'b1, 1'b1, 2'd2, 16'h2b01);
        cyc(4'b0101, 1'b0, 4'b0001, "t3_wrap");
        chk("t3_grant0", 32'(bus.grant_id), 32'd0);
        // ptr=1: idle req1 skipped, req2 wins
        cyc(4'b0101, 1'b0, 4'b0100, "t3_skip1");
        chk("t3_grant2b", 32'(bus.grant_id), 32'd2);
        repeat (6) cyc(4'b0000, 1'b1, 4'b0000, "refill_a");

        // Single 3-flit packet on req0
        fl[0] = mk(1'b1, 1'b0, 2'd0, 16'h1001);
        cyc(4'b0001, 1'b0, 4'b0001, "t2_head");
        fl[0] = mk(1'b0, 1'b0, 2'd0, 16'h1002);
        cyc(4'b0001, 1'b0, 4'b0001, "t2_body");
        fl[0] = mk(1'b0, 1'b1, 2'd0, 16'h1003);
        cyc(4'b0001, 1'b0, 4'b0001, "t2_tail");
        cyc(4'b0000, 1'b0, 4'b0000, "t2_idle");
        chk("t2_grant", 32'(bus.grant_id), 32'd0);
        fl[0] = mk(1'b1, 1'b1, 2'd0, 16'h1101);
        fl[2] = mk(1'b1, 1'b1, 2'd2, 16'h3101);
        cyc(4'b0101, 1'b0, 4'b0100, "t2_rr");
        repeat (4) cyc(4'b0000, 1'b1, 4'b0000, "refill_b");

        // 8-flit packet on req1, credits run out after 7 flits
        for (int k = 0; k < 7; k++) begin
            fl[1] = mk(k == 0, 1'b0, 2'd1, 16'(16'h4000 + k));
            fl[0] = mk(1'b1, 1'b1, 2'd0, 16'h4100);
            cyc((k == 3) ? 4'b0011 : 4'b0010, 1'b0, 4'b0010, "t4_flit");
        end
        fl[1] = mk(1'b0, 1'b1, 2'd1, 16'h4007);
        cyc(4'b0010, 1'b0, 4'b0000, "t4_stall");
        cyc(4'b0010, 1'b1, 4'b0000, "t4_ci");
        cyc(4'b0010, 1'b1, 4'b0010, "t4_tail_ci");
        chk("t4_grant", 32'(bus.grant_id), 32'd1);

        // Credit overflow
        repeat (6) cyc(4'b0000, 1'b1, 4'b0000, "t5_refill");
        chk("t5_err_clear", 32'(bus.err), 32'd0);
        cyc(4'b0000, 1'b1, 4'b0000, "t5_sat");
        chk("t5_err0", 32'(bus.err), 32'd1);
        cyc(4'b0000, 1'b0, 4'b0000, "t5_hold");
        chk("t5_err0_sticky", 32'(bus.err), 32'd1);

        // Body flit while IDLE, then single-flit packets
        fl[1] = mk(1'b0, 1'b0, 2'd1, 16'h5001);
        cyc(4'b0010, 1'b0, 4'b0000, "t6_body");
        chk("t6_err1", 32'(bus.err), 32'd3);
        fl[3] = mk(1'b1, 1'b1, 2'd3, 16'h6001);
        cyc(4'b1000, 1'b0, 4'b1000, "t6_single");
        cyc(4'b0000, 1'b0, 4'b0000, "t6_gap");
        fl[0] = mk(1'b1, 1'b1, 2'd0, 16'h6002);
        cyc(4'b0001, 1'b0, 4'b0001, "t6_idle_again");
        chk("t6_grant", 32'(bus.grant_id), 32'd0);

        // Reset in the middle of a req2 packet
        fl[2] = mk(1'b1, 1'b0, 2'd2, 16'h7001);
        cyc(4'b0100, 1'b0, 4'b0100, "t1_head");
        fl[2] = mk(1'b0, 1'b0, 2'd2, 16'h7002);
        bus.req_flit = {fl[3], fl[2], fl[1], fl[0]};
        rst = 1'b0;
        #1;
        chk("t1_credits",   32'(bus.credits),   32'd7);
        chk("t1_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t1_out_flit",  32'(bus.out_flit),  32'd0);
        chk("t1_err",       32'(bus.err),       32'd0);
        chk("t1_grant",     32'(bus.grant_id),  32'd0);
        chk("t1_ready",     32'(bus.req_ready), 32'd0);
        m_cred    = 7;
        last_flit = '0;
        exp_q.delete();
        @(posedge clk);
        #2 rst = 1'b1;
        cyc(4'b0100, 1'b0, 4'b0000, "t1_abandon");
        fl[1] = mk(1'b1, 1'b1, 2'd1, 16'h7101);
        cyc(4'b0010, 1'b0, 4'b0010, "t1_new");
        chk("t1_err_after", 32'(bus.err), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
